// File: rtl/id_ex_stage.sv
// ID/EX issue register in front of the 64-bit ALU: operand forwarding from EX/MEM and MEM/WB,
// write-back bypass at capture, and a one-cycle bubble on load-use hazards.
module id_ex_stage #(
  parameter int SIZE = 64,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [3:0]      id_op,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [SIZE-1:0] id_rs1_data,
  input  logic [SIZE-1:0] id_rs2_data,
  input  logic [SIZE-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            ex_stall,
  input  logic            flush,
  input  logic [RW-1:0]   exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [SIZE-1:0] exmem_result,
  input  logic [RW-1:0]   memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [SIZE-1:0] memwb_result,
  output logic            ex_valid,
  output logic [3:0]      ex_op,
  output logic [SIZE-1:0] ex_a,
  output logic [SIZE-1:0] ex_b,
  output logic [SIZE-1:0] ex_store_data,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read
);

  logic            v;
  logic [3:0]      op;
  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [RW-1:0]   rd;
  logic [SIZE-1:0] d1;
  logic [SIZE-1:0] d2;
  logic [SIZE-1:0] imm;
  logic            use_imm;
  logic            reg_write;
  logic            mem_read;

  logic            lu;
  logic [SIZE-1:0] fwd1;
  logic [SIZE-1:0] fwd2;

  // Handshake: an instruction moves from decode into this stage on a rising edge where
  // id_valid && id_ready; while id_valid && !id_ready decode must hold every id_* field.
  always_comb begin
    lu = v && mem_read && (rd != '0) &&
         ((id_rs1_used && (id_rs1 == rd)) || (id_rs2_used && (id_rs2 == rd)));
    id_ready = !rst && !ex_stall && !lu;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v         <= 1'b0;
      op        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      d1        <= '0;
      d2        <= '0;
      imm       <= '0;
      use_imm   <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
    end else if (flush) begin
      v         <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
    end else if (ex_stall) begin
      v         <= v;
    end else if (lu || !id_valid) begin
      v         <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      v         <= 1'b1;
      op        <= id_op;
      rs1       <= id_rs1;
      rs2       <= id_rs2;
      rd        <= id_rd;
      imm       <= id_imm;
      use_imm   <= id_use_imm;
      reg_write <= id_reg_write;
      mem_read  <= id_mem_read;
      // The register file is written at the end of this same cycle, so take the
      // write-back value directly rather than the stale read.
      d1 <= (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs1)) ? memwb_result
                                                                          : id_rs1_data;
      d2 <= (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs2)) ? memwb_result
                                                                          : id_rs2_data;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    fwd1 = d1;
    if (rs1 == '0)                                  fwd1 = '0;
    else if (exmem_reg_write && (exmem_rd == rs1))  fwd1 = exmem_result;
    else if (memwb_reg_write && (memwb_rd == rs1))  fwd1 = memwb_result;
  end

  always_comb begin
    fwd2 = d2;
    if (rs2 == '0)                                  fwd2 = '0;
    else if (exmem_reg_write && (exmem_rd == rs2))  fwd2 = exmem_result;
    else if (memwb_reg_write && (memwb_rd == rs2))  fwd2 = memwb_result;
  end

  always_comb begin
    ex_valid      = v;
    ex_op         = op;
    ex_a          = fwd1;
    ex_store_data = fwd2;
    ex_b          = use_imm ? imm : fwd2;
    ex_rd         = rd;
    ex_reg_write  = reg_write && v;
    ex_mem_read   = mem_read && v;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected ALU inputs are queued when an instruction is
// issued and compared when it reaches EX; control outputs are checked inline.
module tb_id_ex_stage;
  localparam int SIZE = 64;
  localparam int RW   = 5;
  localparam int EW   = 4 + 3 * SIZE;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_LUI = 4'b1010;

  logic            clk;
  logic            rst;
  logic            id_valid;
  logic            id_ready;
  logic [3:0]      id_op;
  logic [RW-1:0]   id_rs1, id_rs2, id_rd;
  logic            id_rs1_used, id_rs2_used;
  logic [SIZE-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic            id_use_imm, id_reg_write, id_mem_read;
  logic            ex_stall, flush;
  logic [RW-1:0]   exmem_rd;
  logic            exmem_reg_write;
  logic [SIZE-1:0] exmem_result;
  logic [RW-1:0]   memwb_rd;
  logic            memwb_reg_write;
  logic [SIZE-1:0] memwb_result;
  logic            ex_valid;
  logic [3:0]      ex_op;
  logic [SIZE-1:0] ex_a, ex_b, ex_store_data;
  logic [RW-1:0]   ex_rd;
  logic            ex_reg_write, ex_mem_read;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  id_ex_stage #(.SIZE(SIZE), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_stall(ex_stall), .flush(flush),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper: every check goes through here
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop the expected {op, a, b, store_data} for the instruction now in EX
  task automatic sb_check(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 256'(exp_q.size()), 256'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 256'({ex_op, ex_a, ex_b, ex_store_data}), 256'(e));
      check({tag, "_valid"}, 256'(ex_valid), 256'd1);
    end
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [SIZE-1:0] a,
                          input logic [SIZE-1:0] b, input logic [SIZE-1:0] sd);
    exp_q.push_back({op, a, b, sd});
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, 256'({ex_valid, ex_op, ex_rd, ex_reg_write, ex_mem_read,
                     ex_a, ex_b, ex_store_data}), 256'd0);
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic [RW-1:0] rd, input logic u1, input logic u2,
                       input logic [SIZE-1:0] d1, input logic [SIZE-1:0] d2,
                       input logic [SIZE-1:0] imm, input logic ui,
                       input logic rw, input logic mr);
    id_valid = 1'b1; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_used = u1; id_rs2_used = u2; id_rs1_data = d1; id_rs2_data = d2;
    id_imm = imm; id_use_imm = ui; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_op = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rs1_data = '0; id_rs2_data = '0;
    id_imm = '0; id_use_imm = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
  endtask

  task automatic set_exmem(input logic [RW-1:0] r, input logic w, input logic [SIZE-1:0] res);
    exmem_rd = r; exmem_reg_write = w; exmem_result = res;
  endtask

  task automatic set_memwb(input logic [RW-1:0] r, input logic w, input logic [SIZE-1:0] res);
    memwb_rd = r; memwb_reg_write = w; memwb_result = res;
  endtask

  initial begin
    logic [255:0] held;
    rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    idle();
    set_exmem('0, 1'b0, '0);
    set_memwb('0, 1'b0, '0);
    next_cycle();
    next_cycle();
    check("rst_ready", 256'(id_ready), 256'd0);
    check_reset_vals("rst_outputs");

    // ADD x5 = x1 + x2
    rst = 1'b0;
    issue(OP_ADD, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 64'd3, 64'd4, '0, 1'b0, 1'b1, 1'b0);
    push_exp(OP_ADD, 64'd3, 64'd4, 64'd4);
    settle();
    check("add5_ready", 256'(id_ready), 256'd1);

    // ADD x6 = x5 + x5 (stale register reads)
    next_cycle();
    issue(OP_ADD, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 64'd0, 64'd0, '0, 1'b0, 1'b1, 1'b0);
    push_exp(OP_ADD, 64'd7, 64'd7, 64'd7);
    settle();
    sb_check("add5_ex");
    check("add5_ctrl", 256'({ex_rd, ex_reg_write, ex_mem_read}), 256'({5'd5, 1'b1, 1'b0}));

    // EX/MEM supplies x5=7; issue ADD x11 = x5 + x3
    next_cycle();
    set_exmem(5'd5, 1'b1, 64'd7);
    issue(OP_ADD, 5'd5, 5'd3, 5'd11, 1'b1, 1'b1, 64'd0, 64'h20, '0, 1'b0, 1'b1, 1'b0);
    push_exp(OP_ADD, 64'd9, 64'h20, 64'h20);
    settle();
    sb_check("fwd_exmem");

    // Both stages hold x5: EX/MEM (9) must beat MEM/WB (1); issue ADD x12 = x0 + x3
    next_cycle();
    set_exmem(5'd5, 1'b1, 64'd9);
    set_memwb(5'd5, 1'b1, 64'd1);
    issue(OP_ADD, 5'd0, 5'd3, 5'd12, 1'b1, 1'b1, 64'd0, 64'h20, '0, 1'b0, 1'b1, 1'b0);
    push_exp(OP_ADD, 64'd0, 64'h20, 64'h20);
    settle();
    sb_check("fwd_priority");

    // x0 must never be forwarded; capture ADD x13 = x7 + x3 while MEM/WB writes x7
    next_cycle();
    set_exmem(5'd0, 1'b1, 64'hFF);
    set_memwb(5'd7, 1'b1, 64'h55);
    issue(OP_ADD, 5'd7, 5'd3, 5'd13, 1'b1, 1'b1, 64'h11, 64'h20, '0, 1'b0, 1'b1, 1'b0);
    push_exp(OP_ADD, 64'h55, 64'h20, 64'h20);
    settle();
    sb_check("x0_zero");

    // MEM/WB has moved on; the bypassed value must have been captured. Issue LD x8.
    next_cycle();
    set_exmem('0, 1'b0, '0);
    set_memwb('0, 1'b0, '0);
    issue(OP_ADD, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 64'h100, 64'd0, 64'd8, 1'b1, 1'b1, 1'b1);
    push_exp(OP_ADD, 64'h100, 64'd8, 64'd0);
    settle();
    sb_check("wb_bypass");

    // SUB x9 = x8 - x1 right behind the load
    next_cycle();
    issue(OP_SUB, 5'd8, 5'd1, 5'd9, 1'b1, 1'b1, 64'd0, 64'h100, '0, 1'b0, 1'b1, 1'b0);
    settle();
    sb_check("ld_ex");
    check("ld_memread", 256'(ex_mem_read), 256'd1);
    check("lu_ready", 256'(id_ready), 256'd0);

    // Bubble cycle; the SUB is still presented and is now accepted
    next_cycle();
    push_exp(OP_SUB, 64'hDEAD, 64'h100, 64'h100);
    settle();
    check("lu_bubble", 256'({ex_valid, ex_reg_write, ex_mem_read}), 256'd0);
    check("lu_release", 256'(id_ready), 256'd1);

    // SUB in EX forwards the load result from MEM/WB; issue a second LD x8
    next_cycle();
    set_memwb(5'd8, 1'b1, 64'hDEAD);
    issue(OP_ADD, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 64'h100, 64'd0, 64'd8, 1'b1, 1'b1, 1'b1);
    push_exp(OP_ADD, 64'h100, 64'd8, 64'd0);
    settle();
    sb_check("lu_sub_fwd");

    // Same dependence but rs1 is not actually read: no stall
    next_cycle();
    set_memwb('0, 1'b0, '0);
    issue(OP_SUB, 5'd8, 5'd1, 5'd9, 1'b0, 1'b1, 64'h77, 64'h100, '0, 1'b0, 1'b1, 1'b0);
    push_exp(OP_SUB, 64'h77, 64'h100, 64'h100);
    settle();
    sb_check("ld2_ex");
    check("nolu_ready", 256'(id_ready), 256'd1);

    // ADD x14 for the stall test
    next_cycle();
    issue(OP_ADD, 5'd1, 5'd2, 5'd14, 1'b1, 1'b1, 64'h30, 64'h40, '0, 1'b0, 1'b1, 1'b0);
    push_exp(OP_ADD, 64'h30, 64'h40, 64'h40);
    settle();
    sb_check("nolu_sub_ex");

    next_cycle();
    settle();
    sb_check("add14_ex");
    held = 256'({ex_valid, ex_op, ex_rd, ex_reg_write, ex_a, ex_b});
    ex_stall = 1'b1;
    issue(OP_SUB, 5'd3, 5'd4, 5'd15, 1'b1, 1'b1, 64'd5, 64'd6, '0, 1'b0, 1'b1, 1'b0);
    settle();
    check("stall_ready", 256'(id_ready), 256'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      settle();
      check($sformatf("stall_hold%0d", i),
            256'({ex_valid, ex_op, ex_rd, ex_reg_write, ex_a, ex_b}),
            256'({1'b1, OP_ADD, 5'd14, 1'b1, 64'h30, 64'h40}));
      check($sformatf("stall_ready%0d", i), 256'(id_ready), 256'd0);
    end
    check("stall_snapshot", 256'({ex_valid, ex_op, ex_rd, ex_reg_write, ex_a, ex_b}), held);

    // Flush wins over stall
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    ex_stall = 1'b0;
    idle();
    settle();
    check("flush_kill", 256'({ex_valid, ex_reg_write}), 256'd0);

    // LUI x3 with the immediate on B
    issue(OP_LUI, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 64'd0, 64'd0, 64'h12345000, 1'b1, 1'b1, 1'b0);
    push_exp(OP_LUI, 64'd0, 64'h12345000, 64'd0);
    next_cycle();
    settle();
    sb_check("lui_ex");

    // Reset asserted mid-stall, with a live instruction in EX
    rst = 1'b1;
    ex_stall = 1'b1;
    issue(OP_ADD, 5'd1, 5'd2, 5'd16, 1'b1, 1'b1, 64'd1, 64'd2, '0, 1'b0, 1'b1, 1'b0);
    settle();
    check("rst_mid_ready", 256'(id_ready), 256'd0);
    next_cycle();
    settle();
    check_reset_vals("rst_mid_outputs");
    rst = 1'b0;
    ex_stall = 1'b0;
    idle();
    next_cycle();
    settle();
    check("post_rst_valid", 256'(ex_valid), 256'd0);
    check("sb_drained", 256'(exp_q.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
